muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative HI/LO multiply/divide engine in the execute stage, beside the ALU.
//  Accepts MULT/MULTU/DIV/DIVU from E and computes over many cycles.
//  Drives BUSY into the hazard unit, which stalls D on MFHI/MFLO/MTHI/MTLO/new
//  mul-div while BUSY=1. Holds architectural HI/LO and handles MTHI/MTLO.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  CLK      in   1      clock, all state on rising edge
//  RESET    in   1      synchronous, active-high
//  START    in   1      launch op; sampled only in IDLE
//  OP       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  SRC_A    in   WIDTH  rs: multiplicand / dividend
//  SRC_B    in   WIDTH  rt: multiplier / divisor
//  MTHI     in   1      HI <= SRC_A (IDLE only)
//  MTLO     in   1      LO <= SRC_A (IDLE only)
//  ABORT    in   1      cancel in-flight op (E-stage flush)
//  HI       out  WIDTH  HI register
//  LO       out  WIDTH  LO register
//  BUSY     out  1      1 while state != IDLE, to hazard unit
//  DONE     out  1      1-cycle pulse: HI/LO just updated by an op
// BEHAVIOUR
//  Reset: state IDLE, HI=0, LO=0, BUSY=0, DONE=0, counter=0. Reset mid-op: same
//   result, partial result discarded.
//  FSM IDLE -> CALC -> FIX -> IDLE; BUSY is decoded from state only.
//  IDLE: START=1 latches OP, |A|, |B| (signed ops) or A, B (unsigned),
//   records result signs, counter=0, goes to CALC. START overrides MTHI/MTLO in
//   the same cycle (MT writes dropped). MTHI and MTLO together: both written.
//  CALC: one radix-2 step per cycle, WIDTH cycles (counter 0..WIDTH-1), then FIX.
//   mult: shift-add into 2*WIDTH accumulator. div: restoring, 1 quotient bit/cycle.
//  FIX: sign correction, HI/LO written, next state IDLE, DONE=1 next cycle.
//   MULT: negate 2*WIDTH product if sign(A)^sign(B). DIV: quotient negated if
//   signs differ; remainder takes dividend sign.
//  Latency: START accepted at edge k -> HI/LO valid after edge k+WIDTH+1 (33).
//   BUSY=1 for WIDTH+1 cycles after edge k. DONE=1 only in cycle after k+WIDTH+1.
//  Divide by zero (B=0): LO=all ones, HI=SRC_A unmodified, no sign fix, same
//   latency, no error flag.
//  DIV 0x80000000/-1: LO=0x80000000, HI=0 (wraps, no trap).
//  START/MTHI/MTLO while BUSY: ignored, no state change.
//  ABORT: any state -> IDLE next edge, HI/LO unchanged, DONE=0; ABORT has
//   priority over START in the same cycle.
//  Widths: internal accumulator 2*WIDTH+1 bits; all arithmetic mod 2^WIDTH.
// TESTING
//  RESET 2 cycles -> HI=0, LO=0, BUSY=0, DONE=0.
//  MULTU A=B=0xFFFFFFFF -> 33 cycles BUSY, then HI=0xFFFFFFFE, LO=0x00000001,
//   DONE pulse.
//  MULT A=-3 B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIVU A=0x1234 B=0 -> LO=0xFFFFFFFF, HI=0x00001234.
//  DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  MTHI A=5 in IDLE -> HI=5 next cycle.
//  MTHI during BUSY -> HI unchanged.
//  Second START at cycle 10 of an op -> ignored.
//  ABORT at cycle 10 -> IDLE next edge, HI/LO keep old values, no DONE.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and result bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, abort,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, abort,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO pair.
// Magnitudes are processed for signed ops and the sign is restored in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [AW-1:0]    acc_q, acc_d;

    // Operand conditioning at launch; op[0]=0 selects the signed variants.
    logic             is_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_abs, b_abs, dividend;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.src_a[WIDTH-1];
    assign b_neg     = is_signed & bus.src_b[WIDTH-1];
    assign b_zero    = (bus.src_b == '0);
    assign a_abs     = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs     = b_neg ? -bus.src_b : bus.src_b;
    // A zero divisor leaves the raw dividend in the remainder, so HI ends up as SRC_A.
    assign dividend  = b_zero ? bus.src_a : a_abs;

    logic [WIDTH:0]     mul_sum;
    logic [AW-1:0]      mul_next;
    logic [AW-1:0]      div_shift;
    logic [WIDTH:0]     div_diff;
    logic [AW-1:0]      div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign mul_sum   = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[AW-2:0], 1'b0};
    assign div_diff  = div_shift[AW-1:WIDTH] - {1'b0, opb_q};
    assign div_next  = div_diff[WIDTH] ? div_shift
                                       : {div_diff, div_shift[WIDTH-1:1], 1'b1};

    assign prod_fix  = neg_q     ? -acc_q[2*WIDTH-1:0]     : acc_q[2*WIDTH-1:0];
    assign quot_fix  = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        acc_d     = acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    if (bus.op[1]) begin
                        acc_d     = {{(WIDTH+1){1'b0}}, dividend};
                        opb_d     = b_abs;
                        neg_d     = (a_neg ^ b_neg) & ~b_zero;
                        rem_neg_d = a_neg & ~b_zero;
                    end else begin
                        acc_d     = {{(WIDTH+1){1'b0}}, b_abs};
                        opb_d     = a_abs;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.src_a;
                    if (bus.mtlo) lo_d = bus.src_a;
                end
            end
            S_CALC: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // NOTE: datapath registers carry no reset; START always loads them before they are read.
    always_ff @(posedge clk) begin
        opb_q <= opb_d;
        acc_q <= acc_d;
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, in-flight corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int INJ_NONE  = 0;
    localparam int INJ_MT    = 1;
    localparam int INJ_START = 2;
    localparam int INJ_ABORT = 3;
    localparam int INJ_RESET = 4;

    logic clk = 1'b0;
    logic reset;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t         vecs [10];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] ref_hi   = '0;
    logic [W-1:0] ref_lo   = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural results from plain arithmetic on the operands.
    function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; {hi, lo} = p; end
            2'd1: begin p = {32'b0, a} * {32'b0, b};             {hi, lo} = p; end
            2'd2: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    task automatic mt_write(input logic hi_en, input logic lo_en, input logic [W-1:0] v);
        @(negedge clk);
        bus.mthi  = hi_en;
        bus.mtlo  = lo_en;
        bus.src_a = v;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (hi_en) ref_hi = v;
        if (lo_en) ref_lo = v;
        check("mt_hi", bus.hi, ref_hi);
        check("mt_lo", bus.lo, ref_lo);
        check("mt_busy", 32'(bus.busy), 32'd0);
    endtask

    // Launch one op, optionally disturb it at busy cycle inj_cycle, and check the outcome.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_cycle, input int inj_kind, input logic with_mt);
        logic [W-1:0] exp_hi, exp_lo, hold_hi, hold_lo;
        int cycles, early_done;
        logic cut_short;
        cut_short = (inj_kind == INJ_ABORT) || (inj_kind == INJ_RESET);
        ref_model(op, a, b, exp_hi, exp_lo);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.mthi  = with_mt;
        bus.mtlo  = with_mt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_hi_kept", bus.hi, ref_hi);
        check("start_lo_kept", bus.lo, ref_lo);

        cycles     = 0;
        early_done = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            if (cycles == inj_cycle) begin
                case (inj_kind)
                    INJ_MT:    begin bus.mthi = 1'b1; bus.mtlo = 1'b1; end
                    INJ_START: begin bus.start = 1'b1; bus.op = ~op; end
                    INJ_ABORT: bus.abort = 1'b1;
                    INJ_RESET: reset = 1'b1;
                    default:   ;
                endcase
            end
            @(posedge clk);
            #1;
            bus.mthi  = 1'b0;
            bus.mtlo  = 1'b0;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            reset     = 1'b0;
            if (bus.busy && bus.done) early_done++;
            if (cycles == inj_cycle && inj_kind != INJ_NONE) begin
                hold_hi = (inj_kind == INJ_RESET) ? '0 : ref_hi;
                hold_lo = (inj_kind == INJ_RESET) ? '0 : ref_lo;
                check("inj_hi_hold", bus.hi, hold_hi);
                check("inj_lo_hold", bus.lo, hold_lo);
            end
        end

        if (cut_short) begin
            if (inj_kind == INJ_RESET) begin ref_hi = '0; ref_lo = '0; end
            exp_hi = ref_hi;
            exp_lo = ref_lo;
        end
        check("busy_cycles", 32'(cycles), cut_short ? 32'(inj_cycle) : 32'(LAT));
        check("done_while_busy", 32'(early_done), 32'd0);
        check("done_pulse", 32'(bus.done), cut_short ? 32'd0 : 32'd1);
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
        ref_hi = exp_hi;
        ref_lo = exp_lo;
        @(posedge clk);
        #1;
        check("done_cleared", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{2'd2, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", bus.hi, '0);
        check("reset_lo", bus.lo, '0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        mt_write(1'b1, 1'b0, 32'd5);
        mt_write(1'b0, 1'b1, 32'd9);
        mt_write(1'b1, 1'b1, 32'h0000_0077);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, INJ_NONE, 1'b0);
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
        end

        run_op(2'd0, 32'd11, 32'd13, 0, INJ_NONE, 1'b1);
        run_op(2'd1, 32'h0BAD_F00D, 32'h1357_9BDF, 5, INJ_MT, 1'b0);
        run_op(2'd2, 32'hFFFF_0000, 32'd3, 10, INJ_START, 1'b0);
        run_op(2'd3, 32'hCAFE_BABE, 32'd7, 10, INJ_ABORT, 1'b0);
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 33, INJ_ABORT, 1'b0);
        run_op(2'd1, 32'hDEAD_BEEF, 32'd2, 10, INJ_RESET, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       r_b = '0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 15));
                default: r_b = 32'($urandom);
            endcase
            run_op(r_op, r_a, r_b, 0, INJ_NONE, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
